// File: rtl/uart_cmd_parser.sv
// UART command frame parser: assembles SYNC/OP/A/B/CHK frames from a byte stream,
// validates the XOR checksum and hands accepted commands out through a valid/ready
// register stage. Checksum, inter-byte timeout and overrun faults are 1-cycle strobes.
module uart_cmd_parser #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 104160
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] cmd_op,
  output logic [7:0] cmd_a,
  output logic [7:0] cmd_b,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       err_checksum,
  output logic       err_timeout,
  output logic       err_overrun
);

  localparam int unsigned    CntW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {StHunt, StOpc, StOpa, StOpb, StChk} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      sh_op_q, sh_op_d, sh_a_q, sh_a_d, sh_b_q, sh_b_d;
  logic [7:0]      op_q, op_d, a_q, a_d, b_q, b_d;
  logic            valid_q, valid_d;
  logic            err_chk_q, err_chk_d, err_tmo_q, err_tmo_d, err_ovr_q, err_ovr_d;

  assign cmd_op       = op_q;
  assign cmd_a        = a_q;
  assign cmd_b        = b_q;
  assign cmd_valid    = valid_q;
  assign err_checksum = err_chk_q;
  assign err_timeout  = err_tmo_q;
  assign err_overrun  = err_ovr_q;

  // Next-state: frame assembly, checksum decision, output handshake and idle timeout.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_op_d   = sh_op_q;
    sh_a_d    = sh_a_q;
    sh_b_d    = sh_b_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    valid_d   = valid_q;
    err_chk_d = 1'b0;
    err_tmo_d = 1'b0;
    err_ovr_d = 1'b0;

    // Consumption; a load in the CHK branch below overrides this in the same cycle.
    if (valid_q && cmd_ready) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      StHunt: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d = StOpc;
        end
      end
      StOpc: begin
        if (rx_valid) begin
          sh_op_d = rx_data;
          state_d = StOpa;
        end
      end
      StOpa: begin
        if (rx_valid) begin
          sh_a_d  = rx_data;
          state_d = StOpb;
        end
      end
      StOpb: begin
        if (rx_valid) begin
          sh_b_d  = rx_data;
          state_d = StChk;
        end
      end
      StChk: begin
        if (rx_valid) begin
          state_d = StHunt;
          if (rx_data == (sh_op_q ^ sh_a_q ^ sh_b_q)) begin
            if (!valid_q || cmd_ready) begin
              op_d    = sh_op_q;
              a_d     = sh_a_q;
              b_d     = sh_b_q;
              valid_d = 1'b1;
            end else begin
              err_ovr_d = 1'b1;
            end
          end else begin
            err_chk_d = 1'b1;
          end
        end
      end
      default: state_d = StHunt;
    endcase

    // Idle counter only runs inside a frame; a byte on the expiry cycle wins.
    if (state_q == StHunt) begin
      cnt_d = '0;
    end else if (rx_valid) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      state_d   = StHunt;
      cnt_d     = '0;
      err_tmo_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // State, shadow, output and strobe registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StHunt;
      cnt_q     <= '0;
      sh_op_q   <= '0;
      sh_a_q    <= '0;
      sh_b_q    <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      valid_q   <= 1'b0;
      err_chk_q <= 1'b0;
      err_tmo_q <= 1'b0;
      err_ovr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_op_q   <= sh_op_d;
      sh_a_q    <= sh_a_d;
      sh_b_q    <= sh_b_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      valid_q   <= valid_d;
      err_chk_q <= err_chk_d;
      err_tmo_q <= err_tmo_d;
      err_ovr_q <= err_ovr_d;
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Testbench for uart_cmd_parser: directed frame scenarios plus randomized traffic, checked
// by a byte-list reference model feeding expected-command and expected-error queues.
module tb_uart_cmd_parser;

  localparam int unsigned T    = 40;
  localparam logic [7:0]  SYNC = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       cmd_ready = 1'b0;
  logic [7:0] cmd_op, cmd_a, cmd_b;
  logic       cmd_valid, err_checksum, err_timeout, err_overrun;

  uart_cmd_parser #(
    .SYNC_BYTE      (SYNC),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .cmd_op       (cmd_op),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .err_checksum (err_checksum),
    .err_timeout  (err_timeout),
    .err_overrun  (err_overrun)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state: bytes of the frame in progress, idle gap, output occupancy.
  logic [7:0]  frame[$];
  logic [23:0] exp_cmd[$];
  int          exp_err[$];  // 1 checksum, 2 timeout, 3 overrun
  int          gap = 0;
  bit          occ = 1'b0;
  bit          exp_valid = 1'b0;
  int          rmode = 0;   // 0 ready low, 1 ready high, 2 random

  function automatic void check(string name, int unsigned act, int unsigned req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  function automatic void fail_now(string name, int unsigned act);
    tests++;
    fails++;
    $display("FAIL %s: got %0h, expected nothing (t=%0t)", name, act, $time);
  endfunction

  // One clock of stimulus; the model predicts the effect of the upcoming edge.
  task automatic step(input bit v, input logic [7:0] d);
    bit rdy;
    bit load;
    @(posedge clk);
    #1;
    rdy       = (rmode == 2) ? 1'($urandom_range(0, 1)) : (rmode == 1);
    rx_valid  = v;
    rx_data   = d;
    cmd_ready = rdy;
    exp_valid = occ;
    load      = 1'b0;
    if (v) begin
      gap = 0;
      if (frame.size() == 0) begin
        if (d == SYNC) frame.push_back(d);
      end else begin
        frame.push_back(d);
        if (frame.size() == 5) begin
          if ((frame[1] ^ frame[2] ^ frame[3]) == frame[4]) begin
            if (!occ || rdy) begin
              exp_cmd.push_back({frame[1], frame[2], frame[3]});
              load = 1'b1;
            end else begin
              exp_err.push_back(3);
            end
          end else begin
            exp_err.push_back(1);
          end
          frame.delete();
        end
      end
    end else if (frame.size() != 0) begin
      gap++;
      if (gap == T) begin
        exp_err.push_back(2);
        frame.delete();
        gap = 0;
      end
    end
    if (load) occ = 1'b1;
    else if (occ && rdy) occ = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic send_byte(input logic [7:0] d, input int g);
    idle(g);
    step(1'b1, d);
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input int g);
    send_byte(SYNC, g);
    send_byte(op, g);
    send_byte(a, g);
    send_byte(b, g);
    send_byte(c, g);
  endtask

  // Monitor: per-cycle valid prediction, error strobe queue, command queue on handshake.
  always @(negedge clk) begin
    if (rst) begin
      int nerr;
      int code;
      check("cmd_valid", 32'(cmd_valid), 32'(exp_valid));
      nerr = int'(err_checksum) + int'(err_timeout) + int'(err_overrun);
      if (nerr > 1) begin
        check("err_exclusive", nerr, 1);
      end else if (nerr == 1) begin
        code = err_checksum ? 1 : (err_timeout ? 2 : 3);
        if (exp_err.size() == 0) fail_now("err_unexpected", code);
        else check("err_kind", code, exp_err.pop_front());
      end
      if (cmd_valid && cmd_ready) begin
        if (exp_cmd.size() == 0) fail_now("cmd_unexpected", {cmd_op, cmd_a, cmd_b});
        else check("cmd_fields", {cmd_op, cmd_a, cmd_b}, exp_cmd.pop_front());
      end
    end
  end

  task automatic check_zero_outputs(input string name);
    check({name, "_valid"}, 32'(cmd_valid), 0);
    check({name, "_fields"}, {cmd_op, cmd_a, cmd_b}, 0);
    check({name, "_errs"}, {err_checksum, err_timeout, err_overrun}, 0);
  endtask

  initial begin
    logic [7:0] op, a, b, c;
    int sel;
    int g;

    #12;
    check_zero_outputs("reset_state");
    @(negedge clk);
    rst = 1'b1;

    // Basic accept and hold until ready.
    rmode = 0;
    send_frame(8'h03, 8'h12, 8'h34, 8'h25, 0);
    idle(5);
    rmode = 1;
    idle(3);

    // Bad checksum, then good frame.
    send_frame(8'h03, 8'h12, 8'h34, 8'h26, 0);
    idle(3);
    send_frame(8'h03, 8'h12, 8'h34, 8'h25, 1);
    idle(3);

    // Leading junk; sync value as ordinary operand.
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    send_byte(8'h5A, 0);
    send_frame(8'h01, 8'hA5, 8'h00, 8'hA4, 0);
    idle(3);

    // Timeout aborts, trailing bytes ignored; then bytes exactly on the expiry cycle.
    send_byte(SYNC, 0);
    send_byte(8'h03, 0);
    idle(T);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'h25, 0);
    idle(3);
    send_frame(8'h03, 8'h12, 8'h34, 8'h25, T - 1);
    idle(3);

    // Overrun while first frame held.
    rmode = 0;
    send_frame(8'h03, 8'h12, 8'h34, 8'h25, 0);
    idle(2);
    send_frame(8'h01, 8'h02, 8'h03, 8'h00, 0);
    idle(3);
    rmode = 1;
    idle(3);

    // Back-to-back load on the consuming cycle: no gap in cmd_valid.
    rmode = 0;
    send_frame(8'h03, 8'h12, 8'h34, 8'h25, 0);
    idle(2);
    send_byte(SYNC, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    rmode = 1;
    send_byte(8'h00, 0);
    rmode = 0;
    idle(3);
    rmode = 1;
    idle(3);

    // Asynchronous reset mid-frame with a held command.
    rmode = 0;
    send_frame(8'h0F, 8'h11, 8'h22, 8'h3C, 0);
    send_byte(SYNC, 0);
    send_byte(8'h03, 0);
    send_byte(8'h12, 0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    rx_valid = 1'b0;
    frame.delete();
    exp_cmd.delete();
    exp_err.delete();
    occ = 1'b0;
    exp_valid = 1'b0;
    gap = 0;
    #1;
    check_zero_outputs("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    send_byte(8'h34, 0);
    send_byte(8'h25, 0);
    idle(3);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      rmode = $urandom_range(0, 2);
      sel = $urandom_range(0, 9);
      g = (sel < 7) ? $urandom_range(0, 2) : (sel == 7) ? T - 1 : (sel == 8) ? T : 0;
      op = 8'($urandom);
      a  = 8'($urandom);
      b  = 8'($urandom);
      c  = op ^ a ^ b;
      if ($urandom_range(0, 3) == 0) c = c ^ 8'($urandom_range(1, 255));
      if ($urandom_range(0, 4) == 0) send_byte(8'($urandom), g);
      else send_frame(op, a, b, c, g);
    end

    rmode = 1;
    idle(T + 5);
    check("cmd_queue_drained", exp_cmd.size(), 0);
    check("err_queue_drained", exp_err.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
